pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Game-sequencing controller for the pong pixel/ball datapath: owns game state (idle, serve, play, miss pause, game over), the BCD score, remaining lives and ball speed level.
- Consumes per-frame and collision event pulses from the datapath; drives ball hold/reload and speed-level controls back to it; feeds score to the seven-segment display.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..7)
- SERVE_FRAMES, 120, refresh ticks the ball is held before play begins (>=1)
- MISS_FRAMES, 60, refresh ticks of pause after a miss (>=1)
- HITS_PER_LEVEL, 4, paddle hits per speed-level increment (>=1)
- MAX_LEVEL, 7, speed_level saturation value (<=15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  start button, level, already debounced
- refresh_tick  in  1  one-cycle pulse per frame
- hit  in  1  one-cycle pulse: ball hit the paddle moving right
- miss  in  1  one-cycle pulse: ball passed the right boundary
- ball_hold  out  1  1 = datapath freezes the ball
- ball_reload  out  1  one-cycle pulse: datapath reloads ball position and base velocity
- speed_level  out  4  added to the ball's base x velocity
- score_bcd  out  16  four BCD digits, [3:0] = units
- lives  out  3  remaining lives
- game_over  out  1  high in OVER
- state  out  3  IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4

Behaviour:
- All outputs registered. Reset takes effect at the next clk edge and overrides every input, including mid-game:
  - state=IDLE, ball_hold=1, ball_reload=0, speed_level=0, score_bcd=0, lives=LIVES_INIT, game_over=0
  - internal timer=0, hit_cnt=0, start_d=1
- start_d=1 at reset: a start held through reset does not start a game.
- start_pulse = start & ~start_d; start_d <= start every cycle.
- IDLE:
  - ball_hold=1.
  - start_pulse -> SERVE; score=0, lives=LIVES_INIT, speed_level=0, hit_cnt=0, timer=SERVE_FRAMES-1.
- SERVE:
  - ball_hold=1.
  - ball_reload=1 for exactly the first cycle in SERVE, 0 otherwise.
  - On refresh_tick: timer==0 -> PLAY, else timer--. The ball is held for exactly SERVE_FRAMES ticks.
- PLAY:
  - ball_hold=0.
  - hit: score +1 in BCD with per-digit carry; saturates at 9999.
  - hit, speed: if hit_cnt==HITS_PER_LEVEL-1 then hit_cnt=0 and speed_level=min(speed_level+1, MAX_LEVEL), else hit_cnt++.
  - miss with lives>1: lives--, speed_level=0, hit_cnt=0, timer=MISS_FRAMES-1 -> MISS.
  - miss with lives==1: lives=0 -> OVER.
  - hit and miss in the same cycle: miss wins, hit discarded (no score change).
- MISS:
  - ball_hold=1.
  - On refresh_tick: timer==0 -> SERVE with timer=SERVE_FRAMES-1, else timer--.
- OVER:
  - ball_hold=1, game_over=1; score and speed_level frozen.
  - start_pulse -> SERVE with the same initialisation as from IDLE (game_over clears on the transition).
- Ignored events:
  - hit and miss outside PLAY.
  - start_pulse outside IDLE/OVER.
  - refresh_tick in IDLE, PLAY and OVER (no timer effect).
- Only one transition per cycle. A refresh_tick coinciding with a state entry does not count toward the new state's timer.

Test Plan:
- Reset/start: SERVE_FRAMES=2; hold start high across reset, release, then pulse start -> no start while held; after pulse: state 1, ball_reload high one cycle, lives=3, score=0; PLAY after exactly 2 refresh_ticks.
- BCD and saturation: in PLAY, 10 hit pulses -> score_bcd=16'h0010. Force the score to 9998, 3 hits -> score_bcd=16'h9999.
- Speed level: HITS_PER_LEVEL=2, MAX_LEVEL=3; 8 hits -> speed_level 0,1,1,2,2,3,3,3 sampled after each hit. Then a miss -> speed_level=0, lives=2, state 3.
- Miss pause: MISS_FRAMES=3, SERVE_FRAMES=2 -> MISS for 3 ticks, then SERVE with a one-cycle ball_reload, PLAY after 2 more ticks. Hits during MISS/SERVE leave the score unchanged.
- Game over: LIVES_INIT=2; two misses -> state 4, lives=0, game_over=1, score held. A start pulse in OVER -> SERVE, lives=2, score=0, game_over=0.
- Corner cases:
  - hit and miss in the same cycle -> score unchanged, lives decremented.
  - reset asserted in PLAY with score 0x0042 -> all reset values after one edge.
  - refresh_tick in the same cycle as entry to SERVE -> still exactly SERVE_FRAMES ticks held.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Game-sequencing controller for the pong datapath.
// Tracks game state, BCD score, remaining lives and ball speed level. It
// takes per-frame and collision pulses from the datapath and returns
// ball hold/reload and speed-level controls to it. Every output is a register.
module pong_game_ctrl #(
    parameter int LIVES_INIT     = 3,   // lives loaded at game start (1..7)
    parameter int SERVE_FRAMES   = 120, // refresh ticks the ball is held before play
    parameter int MISS_FRAMES    = 60,  // refresh ticks of pause after a miss
    parameter int HITS_PER_LEVEL = 4,   // paddle hits per speed-level step
    parameter int MAX_LEVEL      = 7    // speed_level saturation value
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        refresh_tick,
    input  logic        hit,
    input  logic        miss,
    output logic        ball_hold,
    output logic        ball_reload,
    output logic [3:0]  speed_level,
    output logic [15:0] score_bcd,
    output logic [2:0]  lives,
    output logic        game_over,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // The frame timer is shared by the serve and miss pauses. It counts
    // down from FRAMES-1 to 0, so it has to hold the larger of the two.
    localparam int TIMER_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam int HIT_W     = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_FRAMES - 1);
    localparam logic [TIMER_W-1:0] MISS_LOAD  = TIMER_W'(MISS_FRAMES - 1);
    localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(HITS_PER_LEVEL - 1);
    localparam logic [3:0]         LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [2:0]         LIVES_LOAD = 3'(LIVES_INIT);

    // Registered state
    state_t               state_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [HIT_W-1:0]     hit_cnt_q;
    logic                 start_d_q;
    logic [15:0]          score_q;
    logic [2:0]           lives_q;
    logic [3:0]           speed_q;
    logic                 hold_q;
    logic                 reload_q;
    logic                 over_q;

    // Next-state values
    state_t               state_d;
    logic [TIMER_W-1:0]   timer_d;
    logic [HIT_W-1:0]     hit_cnt_d;
    logic [15:0]          score_d;
    logic [2:0]           lives_d;
    logic [3:0]           speed_d;
    logic                 hold_d;
    logic                 reload_d;
    logic                 over_d;
    logic                 start_pulse;

    // Add one to a four-digit BCD value. Carries ripple from the units
    // digit upward, and the value saturates at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (v[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // The start button is a level. Only its rising edge starts a game.
    assign start_pulse = start & ~start_d_q;

    // Next-state logic: game sequencing plus score, lives and level bookkeeping
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d   = state_q;
        timer_d   = timer_q;
        hit_cnt_d = hit_cnt_q;
        score_d   = score_q;
        lives_d   = lives_q;
        speed_d   = speed_q;

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start_pulse) begin
                    state_d   = S_SERVE;
                    score_d   = 16'h0000;
                    lives_d   = LIVES_LOAD;
                    speed_d   = 4'd0;
                    hit_cnt_d = '0;
                    timer_d   = SERVE_LOAD;
                end
            end

            S_SERVE: begin
                if (refresh_tick) begin
                    if (timer_q == '0) begin
                        state_d = S_PLAY;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end

            S_PLAY: begin
                // A miss takes priority. A hit in the same cycle is dropped.
                if (miss) begin
                    if (lives_q > 3'd1) begin
                        lives_d   = lives_q - 3'd1;
                        speed_d   = 4'd0;
                        hit_cnt_d = '0;
                        timer_d   = MISS_LOAD;
                        state_d   = S_MISS;
                    end else begin
                        lives_d = 3'd0;
                        state_d = S_OVER;
                    end
                end else if (hit) begin
                    score_d = bcd_inc(score_q);
                    if (hit_cnt_q == HIT_LAST) begin
                        hit_cnt_d = '0;
                        if (speed_q < LEVEL_MAX) begin
                            speed_d = speed_q + 4'd1;
                        end
                    end else begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                end
            end

            S_MISS: begin
                if (refresh_tick) begin
                    if (timer_q == '0) begin
                        state_d = S_SERVE;
                        timer_d = SERVE_LOAD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The ball outputs come from the next state so they line up with
        // the registered state. Reload fires only on the cycle SERVE is entered.
        hold_d   = (state_d != S_PLAY);
        reload_d = (state_d == S_SERVE) && (state_q != S_SERVE);
        over_d   = (state_d == S_OVER);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples the values from before the edge.
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            hit_cnt_q <= '0;
            start_d_q <= 1'b1; // a start held through reset must not count as a press
            score_q   <= 16'h0000;
            lives_q   <= LIVES_LOAD;
            speed_q   <= 4'd0;
            hold_q    <= 1'b1;
            reload_q  <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            hit_cnt_q <= hit_cnt_d;
            start_d_q <= start;
            score_q   <= score_d;
            lives_q   <= lives_d;
            speed_q   <= speed_d;
            hold_q    <= hold_d;
            reload_q  <= reload_d;
            over_q    <= over_d;
        end
    end

    assign state       = state_q;
    assign ball_hold   = hold_q;
    assign ball_reload = reload_q;
    assign speed_level = speed_q;
    assign score_bcd   = score_q;
    assign lives       = lives_q;
    assign game_over   = over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl. Table-driven vectors handle start-up and the
// first miss. Hand-written sequences cover scoring, speed levels, saturation,
// game over and reset. Expected outputs go into a scoreboard queue when the
// stimulus is driven, and each entry is popped and compared once the DUT output is registered.
module tb_pong_game_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        refresh_tick;
    logic        hit;
    logic        miss;
    logic        ball_hold;
    logic        ball_reload;
    logic [3:0]  speed_level;
    logic [15:0] score_bcd;
    logic [2:0]  lives;
    logic        game_over;
    logic [2:0]  state;

    pong_game_ctrl #(
        .LIVES_INIT    (3),
        .SERVE_FRAMES  (2),
        .MISS_FRAMES   (3),
        .HITS_PER_LEVEL(2),
        .MAX_LEVEL     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .refresh_tick(refresh_tick),
        .hit         (hit),
        .miss        (miss),
        .ball_hold   (ball_hold),
        .ball_reload (ball_reload),
        .speed_level (speed_level),
        .score_bcd   (score_bcd),
        .lives       (lives),
        .game_over   (game_over),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic        hold;
        logic        reload;
        logic [3:0]  speed;
        logic [15:0] score;
        logic [2:0]  lives;
        logic        go;
    } exp_t;

    typedef struct {
        logic rst, strt, tick, h, m;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input string name, input bit r, input bit s, input bit t,
                                input bit h, input bit m, input int st, input bit hold,
                                input bit rl, input int spd, input logic [15:0] sc,
                                input int lv, input bit go);
        vec_t v;
        v.rst = r; v.strt = s; v.tick = t; v.h = h; v.m = m;
        v.e.name = name; v.e.st = 3'(st); v.e.hold = hold; v.e.reload = rl;
        v.e.speed = 4'(spd); v.e.score = sc; v.e.lives = 3'(lv); v.e.go = go;
        return v;
    endfunction

    // Decimal integer to four BCD digits, built digit by digit
    function automatic logic [15:0] to_bcd(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic int lvl(input int hits);
        return (hits / 2 > 3) ? 3 : hits / 2;
    endfunction

    task automatic check();
        exp_t x;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got output with no expected entry");
        end else begin
            x = sb.pop_front();
            if ({state, ball_hold, ball_reload, speed_level, score_bcd, lives, game_over} !==
                {x.st, x.hold, x.reload, x.speed, x.score, x.lives, x.go}) begin
                n_err++;
                $display("FAIL %s: got st=%0d hold=%b rl=%b spd=%0d score=%h lives=%0d go=%b, expected st=%0d hold=%b rl=%b spd=%0d score=%h lives=%0d go=%b",
                         x.name, state, ball_hold, ball_reload, speed_level, score_bcd, lives, game_over,
                         x.st, x.hold, x.reload, x.speed, x.score, x.lives, x.go);
            end
        end
    endtask

    // Drive one cycle of inputs on the falling edge, queue the current
    // expectation, then compare just after the next rising edge.
    task automatic step(input logic r, input logic s, input logic t, input logic h,
                        input logic m, input string name);
        @(negedge clk);
        reset = r; start = s; refresh_tick = t; hit = h; miss = m;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic do_reset();
        e.st = 3'd0; e.hold = 1'b1; e.reload = 1'b0; e.speed = 4'd0;
        e.score = 16'h0000; e.lives = 3'd3; e.go = 1'b0;
        step(1, 0, 0, 0, 0, "reset");
        step(0, 0, 0, 0, 0, "idle");
    endtask

    // Start a game from IDLE or OVER and run the serve pause into PLAY
    task automatic to_play();
        e.st = 3'd1; e.hold = 1'b1; e.reload = 1'b1; e.speed = 4'd0;
        e.score = 16'h0000; e.lives = 3'd3; e.go = 1'b0;
        step(0, 1, 0, 0, 0, "start_pulse");
        e.reload = 1'b0;
        step(0, 0, 0, 0, 0, "serve_wait");
        step(0, 0, 1, 0, 0, "serve_tick1");
        e.st = 3'd2; e.hold = 1'b0;
        step(0, 0, 1, 0, 0, "serve_tick2_play");
    endtask

    // From MISS: three ticks to SERVE, then two ticks to PLAY. Hits along the way are ignored.
    task automatic miss_recover();
        step(0, 0, 0, 1, 0, "hit_in_miss");
        step(0, 0, 1, 0, 0, "miss_tick1");
        step(0, 0, 1, 1, 0, "miss_tick2");
        e.st = 3'd1; e.reload = 1'b1;
        step(0, 0, 1, 0, 0, "miss_tick3_serve");
        e.reload = 1'b0;
        step(0, 0, 0, 1, 0, "hit_in_serve");
        step(0, 0, 1, 0, 0, "reserve_tick1");
        e.st = 3'd2; e.hold = 1'b0;
        step(0, 0, 1, 0, 0, "reserve_tick2_play");
    endtask

    vec_t tbl[17];

    initial begin
        reset = 1'b0; start = 1'b0; refresh_tick = 1'b0; hit = 1'b0; miss = 1'b0;

        //            name              rst s t h m  st hold rl spd score     lv go
        tbl[0]  = mk("reset_start_held", 1, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 3, 0);
        tbl[1]  = mk("reset_again",      1, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 3, 0);
        tbl[2]  = mk("start_held_no_go", 0, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 3, 0);
        tbl[3]  = mk("start_released",   0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 3, 0);
        tbl[4]  = mk("start_pulse",      0, 1, 0, 0, 0, 1, 1, 1, 0, 16'h0000, 3, 0);
        tbl[5]  = mk("serve_reload_off", 0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 3, 0);
        tbl[6]  = mk("serve_tick1",      0, 0, 1, 0, 0, 1, 1, 0, 0, 16'h0000, 3, 0);
        tbl[7]  = mk("serve_no_tick",    0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 3, 0);
        tbl[8]  = mk("serve_tick2_play", 0, 0, 1, 0, 0, 2, 0, 0, 0, 16'h0000, 3, 0);
        tbl[9]  = mk("hit1",             0, 0, 0, 1, 0, 2, 0, 0, 0, 16'h0001, 3, 0);
        tbl[10] = mk("hit2_level",       0, 0, 0, 1, 0, 2, 0, 0, 1, 16'h0002, 3, 0);
        tbl[11] = mk("hit_and_miss",     0, 0, 0, 1, 1, 3, 1, 0, 0, 16'h0002, 2, 0);
        tbl[12] = mk("miss_tick1_hit",   0, 0, 1, 1, 0, 3, 1, 0, 0, 16'h0002, 2, 0);
        tbl[13] = mk("miss_tick2",       0, 0, 1, 0, 0, 3, 1, 0, 0, 16'h0002, 2, 0);
        tbl[14] = mk("miss_tick3_serve", 0, 0, 1, 0, 0, 1, 1, 1, 0, 16'h0002, 2, 0);
        tbl[15] = mk("reserve_tick1",    0, 0, 1, 1, 0, 1, 1, 0, 0, 16'h0002, 2, 0);
        tbl[16] = mk("reserve_tick2",    0, 0, 1, 0, 0, 2, 0, 0, 0, 16'h0002, 2, 0);

        foreach (tbl[i]) begin
            e = tbl[i].e;
            step(tbl[i].rst, tbl[i].strt, tbl[i].tick, tbl[i].h, tbl[i].m, tbl[i].e.name);
        end

        // Speed levels with saturation at 3, then BCD carry into the tens digit
        do_reset();
        to_play();
        for (int i = 1; i <= 10; i++) begin
            e.score = to_bcd(i);
            e.speed = 4'(lvl(i));
            step(0, 0, 0, 1, 0, (i == 10) ? "bcd_carry_0010" : "speed_hit");
        end
        step(0, 1, 0, 0, 0, "start_in_play_ignored");
        step(0, 0, 0, 0, 0, "play_idle");
        step(0, 0, 1, 0, 0, "tick_in_play_ignored");

        // Simultaneous hit and miss: the miss wins
        e.st = 3'd3; e.hold = 1'b1; e.speed = 4'd0; e.lives = 3'd2;
        step(0, 0, 0, 1, 1, "hit_miss_same_cycle");
        miss_recover();
        e.score = 16'h0011; step(0, 0, 0, 1, 0, "hit_after_recover");
        e.score = 16'h0012; e.speed = 4'd1; step(0, 0, 0, 1, 0, "hit_level_up");
        e.st = 3'd3; e.hold = 1'b1; e.speed = 4'd0; e.lives = 3'd1;
        step(0, 0, 0, 0, 1, "second_miss");
        miss_recover();
        e.score = 16'h0013; step(0, 0, 0, 1, 0, "hit_13");
        e.score = 16'h0014; e.speed = 4'd1; step(0, 0, 0, 1, 0, "hit_14");

        // Last life lost: OVER freezes score and speed level
        e.st = 3'd4; e.hold = 1'b1; e.lives = 3'd0; e.go = 1'b1;
        step(0, 0, 0, 0, 1, "game_over");
        step(0, 0, 1, 1, 0, "over_hit_tick_ignored");
        step(0, 0, 0, 0, 1, "over_miss_ignored");
        to_play();

        // Score saturation at 9999
        do_reset();
        to_play();
        for (int i = 1; i <= 9998; i++) begin
            e.score = to_bcd(i);
            e.speed = 4'(lvl(i));
            step(0, 0, 0, 1, 0, "score_count");
        end
        e.score = 16'h9999;
        step(0, 0, 0, 1, 0, "score_9999");
        step(0, 0, 0, 1, 0, "score_sat1");
        step(0, 0, 0, 1, 0, "score_sat2");

        // Reset in the middle of a game with score 0042
        do_reset();
        to_play();
        for (int i = 1; i <= 42; i++) begin
            e.score = to_bcd(i);
            e.speed = 4'(lvl(i));
            step(0, 0, 0, 1, 0, "score_to_42");
        end
        do_reset();

        // A refresh tick on the cycle SERVE is entered does not count
        e.st = 3'd1; e.reload = 1'b1;
        step(0, 1, 1, 0, 0, "start_with_tick");
        e.reload = 1'b0;
        step(0, 0, 1, 0, 0, "entry_tick_not_counted");
        e.st = 3'd2; e.hold = 1'b0;
        step(0, 0, 1, 0, 0, "play_after_two_ticks");

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
